// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared constants, coefficient indices and loader states for the IIR coefficient loader.
package iir_pkg;

  localparam int DEF_COEFF_WIDTH = 16;
  localparam int NUM_COEFFS      = 10;

  // Frame word order: section 1 (b0, b1, b2, a1, a2), then section 2.
  localparam int IDX_B0_1 = 0;
  localparam int IDX_B1_1 = 1;
  localparam int IDX_B2_1 = 2;
  localparam int IDX_A1_1 = 3;
  localparam int IDX_A2_1 = 4;
  localparam int IDX_B0_2 = 5;
  localparam int IDX_B1_2 = 6;
  localparam int IDX_B2_2 = 7;
  localparam int IDX_A1_2 = 8;
  localparam int IDX_A2_2 = 9;

  localparam logic [DEF_COEFF_WIDTH-1:0] UNITY = {2'b01, {(DEF_COEFF_WIDTH-2){1'b0}}};

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    DRAIN   = 2'd1,
    PENDING = 2'd2,
    CHECK   = 2'd3
  } state_t;

endpackage

// File: rtl/iir_biquad_stable_chk.sv
// rtl/iir_biquad_stable_chk.sv - combinational stability-triangle test for one biquad section.
module iir_biquad_stable_chk
  import iir_pkg::*;
#(
  parameter int COEFF_WIDTH = DEF_COEFF_WIDTH
) (
  input  logic [COEFF_WIDTH-1:0] a1,
  input  logic [COEFF_WIDTH-1:0] a2,
  output logic                   stable
);

  localparam int W = COEFF_WIDTH;

  // One extra bit so |-2^(W-1)| and unity + a2 both fit without wrapping.
  logic signed [W:0] unity;
  logic signed [W:0] a1_x, a2_x, a1_abs, a2_abs, a1_lim;

  assign unity  = signed'({3'b001, {(W-2){1'b0}}});
  assign a1_x   = signed'({a1[W-1], a1});
  assign a2_x   = signed'({a2[W-1], a2});
  assign a1_abs = a1_x[W] ? -a1_x : a1_x;
  assign a2_abs = a2_x[W] ? -a2_x : a2_x;
  assign a1_lim = unity + a2_x;
  assign stable = (a2_abs < unity) && (a1_abs < a1_lim);

endmodule

// File: rtl/iir_coeff_loader.sv
// rtl/iir_coeff_loader.sv - streams a 10-word coefficient frame into a shadow bank and commits it atomically on sample_stb.
// Optional IIR_COEFF_STABILITY_CHECK_EN adds a one-cycle stability check before a frame may commit.
module iir_coeff_loader
  import iir_pkg::*;
#(
  parameter int COEFF_WIDTH = DEF_COEFF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [COEFF_WIDTH-1:0] s_data,
  input  logic                   s_last,
  input  logic                   sample_stb,
  output logic [COEFF_WIDTH-1:0] b0_1,
  output logic [COEFF_WIDTH-1:0] b1_1,
  output logic [COEFF_WIDTH-1:0] b2_1,
  output logic [COEFF_WIDTH-1:0] a1_1,
  output logic [COEFF_WIDTH-1:0] a2_1,
  output logic [COEFF_WIDTH-1:0] b0_2,
  output logic [COEFF_WIDTH-1:0] b1_2,
  output logic [COEFF_WIDTH-1:0] b2_2,
  output logic [COEFF_WIDTH-1:0] a1_2,
  output logic [COEFF_WIDTH-1:0] a2_2,
  output logic                   coeff_updated,
  output logic                   frame_err,
  output logic                   pending
);

  localparam int W = COEFF_WIDTH;
  localparam logic [W-1:0] UNITY_W = {2'b01, {(W-2){1'b0}}};

  logic [1:0]   rel;
  logic         run;
  state_t       state, state_nxt;
  logic [3:0]   cnt, cnt_nxt;
  logic [W-1:0] shadow [NUM_COEFFS];
  logic [W-1:0] active [NUM_COEFFS];
  logic         accept, last_idx, wr_en, commit, err_nxt;

  // Reset release is re-timed so the stream opens two clocks after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rel <= 2'b00;
    else      rel <= {rel[0], 1'b1};
  end
  assign run = rel[1];

  assign s_ready  = run && ((state == LOAD) || (state == DRAIN));
  assign pending  = (state == PENDING);
  assign accept   = s_valid && s_ready;
  assign last_idx = (cnt == 4'(NUM_COEFFS - 1));

`ifdef IIR_COEFF_STABILITY_CHECK_EN
  logic stable_1, stable_2;

  iir_biquad_stable_chk #(.COEFF_WIDTH(W)) u_chk_1 (
    .a1(shadow[IDX_A1_1]), .a2(shadow[IDX_A2_1]), .stable(stable_1)
  );
  iir_biquad_stable_chk #(.COEFF_WIDTH(W)) u_chk_2 (
    .a1(shadow[IDX_A1_2]), .a2(shadow[IDX_A2_2]), .stable(stable_2)
  );
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    commit    = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      LOAD: begin
        if (accept) begin
          if (!last_idx) begin
            if (s_last) begin
              err_nxt = 1'b1;
              cnt_nxt = '0;
            end else begin
              wr_en   = 1'b1;
              cnt_nxt = cnt + 4'd1;
            end
          end else begin
            cnt_nxt = '0;
            if (s_last) begin
              wr_en = 1'b1;
`ifdef IIR_COEFF_STABILITY_CHECK_EN
              state_nxt = CHECK;
`else
              state_nxt = PENDING;
`endif
            end else begin
              err_nxt   = 1'b1;
              state_nxt = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (accept && s_last) state_nxt = LOAD;
      end
      PENDING: begin
        if (sample_stb) begin
          commit    = 1'b1;
          state_nxt = LOAD;
        end
      end
      CHECK: begin
`ifdef IIR_COEFF_STABILITY_CHECK_EN
        if (stable_1 && stable_2) begin
          state_nxt = PENDING;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = LOAD;
        end
`else
        state_nxt = LOAD;
`endif
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= LOAD;
      cnt           <= '0;
      coeff_updated <= 1'b0;
      frame_err     <= 1'b0;
      for (int i = 0; i < NUM_COEFFS; i++) begin
        shadow[i] <= '0;
        active[i] <= ((i == IDX_B0_1) || (i == IDX_B0_2)) ? UNITY_W : '0;
      end
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      coeff_updated <= commit;
      frame_err     <= err_nxt;
      if (wr_en) shadow[cnt] <= s_data;
      if (commit) begin
        for (int i = 0; i < NUM_COEFFS; i++) active[i] <= shadow[i];
      end
    end
  end

  assign b0_1 = active[IDX_B0_1];
  assign b1_1 = active[IDX_B1_1];
  assign b2_1 = active[IDX_B2_1];
  assign a1_1 = active[IDX_A1_1];
  assign a2_1 = active[IDX_A2_1];
  assign b0_2 = active[IDX_B0_2];
  assign b1_2 = active[IDX_B1_2];
  assign b2_2 = active[IDX_B2_2];
  assign a1_2 = active[IDX_A1_2];
  assign a2_2 = active[IDX_A2_2];

endmodule

// File: tb/tb_iir_coeff_loader.sv
// tb/tb_iir_coeff_loader.sv - directed self-checking bench for iir_coeff_loader.
module tb_iir_coeff_loader;

  localparam int W = 16;
`ifdef IIR_COEFF_STABILITY_CHECK_EN
  localparam logic signed [W-1:0] A1_NOM = -16'sd29000;
`else
  localparam logic signed [W-1:0] A1_NOM = -16'sd30000;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         sample_stb = 1'b0;
  logic [W-1:0] s_data = '0;
  logic         s_ready, coeff_updated, frame_err, pending;
  logic [W-1:0] b0_1, b1_1, b2_1, a1_1, a2_1, b0_2, b1_2, b2_2, a1_2, a2_2;

  logic [W-1:0] act [10];
  logic [W-1:0] frm [12];
  logic [W-1:0] exp_bank [10];
  int n_checks = 0;
  int n_fail = 0;

  iir_coeff_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .sample_stb(sample_stb),
    .b0_1(b0_1), .b1_1(b1_1), .b2_1(b2_1), .a1_1(a1_1), .a2_1(a2_1),
    .b0_2(b0_2), .b1_2(b1_2), .b2_2(b2_2), .a1_2(a1_2), .a2_2(a2_2),
    .coeff_updated(coeff_updated), .frame_err(frame_err), .pending(pending)
  );

  always #5 clk = ~clk;

  assign act[0] = b0_1; assign act[1] = b1_1; assign act[2] = b2_1;
  assign act[3] = a1_1; assign act[4] = a2_1; assign act[5] = b0_2;
  assign act[6] = b1_2; assign act[7] = b2_2; assign act[8] = a1_2;
  assign act[9] = a2_2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic last, input logic stb);
    s_valid = 1'b1; s_data = d; s_last = last;
    for (int k = 0; k < 20 && !s_ready; k++) tick();
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++; $display("FAIL send_ready: s_ready=%b required 1", s_ready);
    end
    sample_stb = stb;
    tick();
    s_valid = 1'b0; s_last = 1'b0; sample_stb = 1'b0;
  endtask

  task automatic set_frame_a();
    for (int s = 0; s < 2; s++) begin
      frm[5*s]   = 16'd2209;
      frm[5*s+1] = 16'd4419;
      frm[5*s+2] = 16'd2209;
      frm[5*s+3] = A1_NOM;
      frm[5*s+4] = 16'd13552;
    end
    frm[10] = 16'd7;
    frm[11] = 16'd9;
  endtask

  task automatic set_frame_b();
    frm[0] = 16'sd100;  frm[1] = 16'sd200;  frm[2] = 16'sd300;  frm[3] = -16'sd400;
    frm[4] = 16'sd500;  frm[5] = -16'sd600; frm[6] = 16'sd700;  frm[7] = -16'sd800;
    frm[8] = 16'sd900;  frm[9] = -16'sd1000; frm[10] = '0; frm[11] = '0;
  endtask

  task automatic set_exp_default();
    for (int i = 0; i < 10; i++) exp_bank[i] = '0;
    exp_bank[0] = 16'd16384;
    exp_bank[5] = 16'd16384;
  endtask

  task automatic set_exp_from_frame();
    for (int i = 0; i < 10; i++) exp_bank[i] = frm[i];
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    set_exp_default();
    n_checks++;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", s_ready); end
    n_checks++;
    if ({pending, coeff_updated, frame_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: pend/upd/err=%b required 000", {pending, coeff_updated, frame_err});
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (act[i] !== exp_bank[i]) begin
        n_fail++; $display("FAIL reset_bank[%0d]: got %0d required %0d", i, $signed(act[i]), $signed(exp_bank[i]));
      end
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL release_ready_1: got %b required 0", s_ready); end
    tick();
    n_checks++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready_2: got %b required 1", s_ready); end
  endtask

  task automatic test_nominal();
    set_frame_a();
    for (int i = 0; i < 10; i++) send_word(frm[i], i == 9, 1'b0);
    for (int k = 0; k < 4 && !pending; k++) tick();
    n_checks++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL nominal_pending: got %b required 1", pending); end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if ({pending, coeff_updated, b1_1} !== {2'b10, 16'd0}) begin
        n_fail++; $display("FAIL nominal_wait: pend=%b upd=%b b1_1=%0d required 1 0 0", pending, coeff_updated, b1_1);
      end
    end
    sample_stb = 1'b1; tick(); sample_stb = 1'b0;
    set_exp_from_frame();
    n_checks++;
    if ({coeff_updated, pending} !== 2'b10) begin
      n_fail++; $display("FAIL nominal_commit: upd/pend=%b required 10", {coeff_updated, pending});
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (act[i] !== exp_bank[i]) begin
        n_fail++; $display("FAIL nominal_bank[%0d]: got %0d required %0d", i, $signed(act[i]), $signed(exp_bank[i]));
      end
    end
    tick();
    n_checks++;
    if (coeff_updated !== 1'b0) begin n_fail++; $display("FAIL nominal_upd_pulse: got %b required 0", coeff_updated); end
  endtask

  task automatic test_short_frame();
    set_frame_b();
    for (int i = 0; i < 4; i++) send_word(frm[i], i == 3, 1'b0);
    n_checks++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL short_err: got %b required 1", frame_err); end
    tick();
    n_checks++;
    if ({frame_err, pending} !== 2'b00) begin
      n_fail++; $display("FAIL short_after: err/pend=%b required 00", {frame_err, pending});
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (act[i] !== exp_bank[i]) begin
        n_fail++; $display("FAIL short_bank[%0d]: got %0d required %0d", i, $signed(act[i]), $signed(exp_bank[i]));
      end
    end
    for (int i = 0; i < 10; i++) send_word(frm[i], i == 9, 1'b0);
    for (int k = 0; k < 4 && !pending; k++) tick();
    sample_stb = 1'b1; tick(); sample_stb = 1'b0;
    set_exp_from_frame();
    n_checks++;
    if (coeff_updated !== 1'b1) begin n_fail++; $display("FAIL short_followup_upd: got %b required 1", coeff_updated); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (act[i] !== exp_bank[i]) begin
        n_fail++; $display("FAIL short_followup_bank[%0d]: got %0d required %0d", i, $signed(act[i]), $signed(exp_bank[i]));
      end
    end
  endtask

  task automatic test_long_frame();
    set_frame_a();
    for (int i = 0; i < 12; i++) begin
      send_word(frm[i], i == 11, 1'b0);
      n_checks++;
      if (frame_err !== (i == 9)) begin
        n_fail++; $display("FAIL long_err_word%0d: got %b required %b", i + 1, frame_err, (i == 9));
      end
    end
    tick(); tick();
    n_checks++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL long_pending: got %b required 0", pending); end
    sample_stb = 1'b1; tick(); sample_stb = 1'b0;
    n_checks++;
    if (coeff_updated !== 1'b0) begin n_fail++; $display("FAIL long_upd: got %b required 0", coeff_updated); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (act[i] !== exp_bank[i]) begin
        n_fail++; $display("FAIL long_bank[%0d]: got %0d required %0d", i, $signed(act[i]), $signed(exp_bank[i]));
      end
    end
  endtask

  task automatic test_collision();
    set_frame_a();
    for (int i = 0; i < 9; i++) send_word(frm[i], 1'b0, 1'b0);
    send_word(frm[9], 1'b1, 1'b1);
    n_checks++;
    if ({coeff_updated, b1_1} !== {1'b0, 16'd200}) begin
      n_fail++; $display("FAIL collision_nocommit: upd=%b b1_1=%0d required 0 200", coeff_updated, b1_1);
    end
    for (int k = 0; k < 4 && !pending; k++) tick();
    s_valid = 1'b1; s_data = 16'h1234; s_last = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      n_checks++;
      if ({s_ready, pending, coeff_updated} !== 3'b010) begin
        n_fail++; $display("FAIL backpressure: rdy/pend/upd=%b required 010", {s_ready, pending, coeff_updated});
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    sample_stb = 1'b1; tick(); sample_stb = 1'b0;
    set_exp_from_frame();
    n_checks++;
    if ({coeff_updated, pending} !== 2'b10) begin
      n_fail++; $display("FAIL collision_commit: upd/pend=%b required 10", {coeff_updated, pending});
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (act[i] !== exp_bank[i]) begin
        n_fail++; $display("FAIL collision_bank[%0d]: got %0d required %0d", i, $signed(act[i]), $signed(exp_bank[i]));
      end
    end
  endtask

`ifdef IIR_COEFF_STABILITY_CHECK_EN
  task automatic test_stability();
    logic seen;
    set_frame_b();
    frm[4] = 16'd16384;
    for (int i = 0; i < 10; i++) send_word(frm[i], i == 9, 1'b0);
    seen = frame_err;
    for (int k = 0; k < 4; k++) begin tick(); seen = seen | frame_err; end
    n_checks++;
    if ({seen, pending} !== 2'b10) begin
      n_fail++; $display("FAIL stab_reject: err_seen/pend=%b required 10", {seen, pending});
    end
    n_checks++;
    if (a2_1 !== 16'd13552) begin n_fail++; $display("FAIL stab_bank: a2_1=%0d required 13552", a2_1); end
    frm[4] = 16'd13552;
    for (int i = 0; i < 10; i++) send_word(frm[i], i == 9, 1'b0);
    for (int k = 0; k < 4 && !pending; k++) tick();
    sample_stb = 1'b1; tick(); sample_stb = 1'b0;
    set_exp_from_frame();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (act[i] !== exp_bank[i]) begin
        n_fail++; $display("FAIL stab_commit_bank[%0d]: got %0d required %0d", i, $signed(act[i]), $signed(exp_bank[i]));
      end
    end
  endtask
`endif

  task automatic test_midframe_reset();
    set_frame_b();
    for (int i = 0; i < 5; i++) send_word(frm[i], 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    set_exp_default();
    n_checks++;
    if ({s_ready, pending} !== 2'b00) begin
      n_fail++; $display("FAIL midreset_flags: rdy/pend=%b required 00", {s_ready, pending});
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (act[i] !== exp_bank[i]) begin
        n_fail++; $display("FAIL midreset_bank[%0d]: got %0d required %0d", i, $signed(act[i]), $signed(exp_bank[i]));
      end
    end
    tick();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b required 1", s_ready); end
    set_frame_a();
    for (int i = 0; i < 10; i++) send_word(frm[i], i == 9, 1'b0);
    for (int k = 0; k < 4 && !pending; k++) tick();
    sample_stb = 1'b1; tick(); sample_stb = 1'b0;
    set_exp_from_frame();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (act[i] !== exp_bank[i]) begin
        n_fail++; $display("FAIL midreset_reload[%0d]: got %0d required %0d", i, $signed(act[i]), $signed(exp_bank[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_frame();
    test_long_frame();
    test_collision();
`ifdef IIR_COEFF_STABILITY_CHECK_EN
    test_stability();
`endif
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
